// File: rtl/torv32_pkg.sv
// Shared definitions for the RV32I core's branch predictor: 2-bit counter
// encodings, predictor FSM states and the saturating counter update.
package torv32_pkg;

    localparam logic [1:0] CNT_SNT = 2'd0;
    localparam logic [1:0] CNT_WNT = 2'd1;
    localparam logic [1:0] CNT_WT  = 2'd2;
    localparam logic [1:0] CNT_ST  = 2'd3;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bht_state_e;

    function automatic logic [1:0] sat2(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Lookup/update/statistics bundle between the pipeline (master) and the
// branch history table predictor (slave).
interface bht_predictor_if #(
    parameter int IDX_BITS = 4
);
    logic                p_en;
    logic [31:0]         p_pc;
    logic                p_taken;
    logic [IDX_BITS-1:0] p_index;
    logic [1:0]          p_cnt;

    logic                u_valid;
    logic [IDX_BITS-1:0] u_index;
    logic [1:0]          u_cnt;
    logic                u_taken;
    logic                u_pred;

    logic [31:0]         stat_branches;
    logic [31:0]         stat_hits;

    modport master (
        output p_en, p_pc, u_valid, u_index, u_cnt, u_taken, u_pred,
        input  p_taken, p_index, p_cnt, stat_branches, stat_hits
    );

    modport slave (
        input  p_en, p_pc, u_valid, u_index, u_cnt, u_taken, u_pred,
        output p_taken, p_index, p_cnt, stat_branches, stat_hits
    );
endinterface

// File: rtl/bht_ram.sv
// 2^IDX_BITS x 2-bit counter store: one write port, one synchronous read port,
// write-first when both ports hit the same entry in the same cycle.
module bht_ram #(
    parameter int         IDX_BITS = 4,
    parameter logic [1:0] RST_VAL  = 2'b01
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                we_i,
    input  logic [IDX_BITS-1:0] waddr_i,
    input  logic [1:0]          wdata_i,
    input  logic                re_i,
    input  logic [IDX_BITS-1:0] raddr_i,
    output logic [1:0]          rdata_o
);
    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0] mem [ENTRIES];
    logic [1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Output register resets so the decode stage sees a defined counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= RST_VAL;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bht_predictor.sv
// Dynamic branch predictor: 2-bit saturating counters indexed bimodally or by
// gshare hash, initialised by a sweep after reset, with branch/hit statistics.
module bht_predictor
    import torv32_pkg::*;
#(
    parameter int         IDX_BITS  = 4,
    parameter int         HIST_BITS = 4,
    parameter int         MODE      = 1,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic           clk,
    input  logic           resetn,
    output logic           busy,
    bht_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_BITS;

    bht_state_e            state_q, state_d;
    logic [IDX_BITS-1:0]   ptr_q, ptr_d;
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic [IDX_BITS-1:0]   p_index_q, p_index_d;
    logic [31:0]           br_q, br_d;
    logic [31:0]           hit_q, hit_d;

    logic                  ram_we;
    logic [IDX_BITS-1:0]   ram_waddr;
    logic [1:0]            ram_wdata;
    logic                  ram_re;
    logic [1:0]            ram_rdata;

    logic [IDX_BITS-1:0]   pc_idx;
    logic [IDX_BITS-1:0]   hash_idx;
    logic                  unused_pc_bits;

    assign pc_idx         = bus.p_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{bus.p_pc[31:IDX_BITS+2], bus.p_pc[1:0]};

    // gshare uses the history as it stood before any same-cycle resolution.
    assign hash_idx = (MODE == 1) ? (pc_idx ^ IDX_BITS'(ghr_q)) : pc_idx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= INIT;
            ptr_q     <= '0;
            ghr_q     <= '0;
            p_index_q <= '0;
            br_q      <= '0;
            hit_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ghr_q     <= ghr_d;
            p_index_q <= p_index_d;
            br_q      <= br_d;
            hit_q     <= hit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ghr_d     = ghr_q;
        p_index_d = p_index_q;
        br_d      = br_q;
        hit_d     = hit_q;
        ram_we    = 1'b0;
        ram_waddr = bus.u_index;
        ram_wdata = sat2(bus.u_cnt, bus.u_taken);
        ram_re    = 1'b0;

        case (state_q)
            INIT: begin
                ram_we    = 1'b1;
                ram_waddr = ptr_q;
                ram_wdata = CNT_INIT;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == IDX_BITS'(ENTRIES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ram_re = bus.p_en;
                if (bus.p_en) begin
                    p_index_d = hash_idx;
                end
                // History and statistics advance only on resolved branches.
                if (bus.u_valid) begin
                    ram_we = 1'b1;
                    ghr_d  = (ghr_q << 1) | HIST_BITS'(bus.u_taken);
                    br_d   = br_q + 32'd1;
                    if (bus.u_taken == bus.u_pred) begin
                        hit_d = hit_q + 32'd1;
                    end
                end
            end
        endcase
    end

    bht_ram #(
        .IDX_BITS (IDX_BITS),
        .RST_VAL  (CNT_INIT)
    ) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (hash_idx),
        .rdata_o (ram_rdata)
    );

    assign busy              = (state_q == INIT);
    assign bus.p_index       = p_index_q;
    assign bus.p_cnt         = ram_rdata;
    assign bus.p_taken       = (state_q == RUN) && ram_rdata[1];
    assign bus.stat_branches = br_q;
    assign bus.stat_hits     = hit_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench: a bimodal and a gshare predictor share clock and reset;
// expected values are hand-derived counter/history/statistics results.
module tb_bht_predictor;

    logic clk = 1'b0;
    logic resetn;
    logic busy0, busy1;
    int   total = 0;
    int   bad   = 0;
    int   n;

    always #5 clk = ~clk;

    bht_predictor_if #(.IDX_BITS(4)) b0 ();
    bht_predictor_if #(.IDX_BITS(4)) b1 ();

    bht_predictor #(.IDX_BITS(4), .HIST_BITS(4), .MODE(0), .CNT_INIT(2'b01)) u0 (
        .clk    (clk),
        .resetn (resetn),
        .busy   (busy0),
        .bus    (b0.slave)
    );

    bht_predictor #(.IDX_BITS(4), .HIST_BITS(4), .MODE(1), .CNT_INIT(2'b01)) u1 (
        .clk    (clk),
        .resetn (resetn),
        .busy   (busy1),
        .bus    (b1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b0.p_en = 0; b0.p_pc = '0; b0.u_valid = 0; b0.u_index = '0;
        b0.u_cnt = '0; b0.u_taken = 0; b0.u_pred = 0;
        b1.p_en = 0; b1.p_pc = '0; b1.u_valid = 0; b1.u_index = '0;
        b1.u_cnt = '0; b1.u_taken = 0; b1.u_pred = 0;
    endtask

    task automatic lookup0(input logic [31:0] pc);
        b0.p_pc = pc; b0.p_en = 1; tick(); b0.p_en = 0;
    endtask

    task automatic lookup1(input logic [31:0] pc);
        b1.p_pc = pc; b1.p_en = 1; tick(); b1.p_en = 0;
    endtask

    task automatic upd0(input logic [3:0] idx, input logic [1:0] cnt, input logic tk, input logic pr);
        b0.p_en = 0; b0.u_valid = 1; b0.u_index = idx; b0.u_cnt = cnt;
        b0.u_taken = tk; b0.u_pred = pr;
        tick();
        b0.u_valid = 0;
    endtask

    task automatic upd1(input logic [3:0] idx, input logic [1:0] cnt, input logic tk, input logic pr);
        b1.p_en = 0; b1.u_valid = 1; b1.u_index = idx; b1.u_cnt = cnt;
        b1.u_taken = tk; b1.u_pred = pr;
        tick();
        b1.u_valid = 0;
    endtask

    initial begin
        logic [1:0] sat_up [3]  = '{2'd2, 2'd3, 2'd3};
        logic [1:0] sat_dn [4]  = '{2'd2, 2'd1, 2'd0, 2'd0};
        logic       tk_dn  [4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       gs_tk  [3]  = '{1'b1, 1'b0, 1'b1};
        logic       st_tk  [10] = '{1,1,0,0,1,0,1,1,0,1};
        logic       st_pr  [10] = '{1,0,0,1,1,0,1,0,0,1};

        idle();
        resetn = 0;
        tick();
        check("rst_busy", busy0, 1);
        check("rst_taken", b0.p_taken, 0);
        check("rst_index", b0.p_index, 0);
        check("rst_cnt", b0.p_cnt, 1);
        check("rst_branches", b0.stat_branches, 0);
        check("rst_hits", b0.stat_hits, 0);
        resetn = 1;

        // Sweep with an update and a lookup pending: both must be ignored.
        b0.u_valid = 1; b0.u_index = 4'd3; b0.u_cnt = 2'd3; b0.u_taken = 1; b0.u_pred = 1;
        b0.p_en = 1; b0.p_pc = 32'h0C;
        n = 0;
        while (busy0 && n < 100) begin
            check("init_taken", b0.p_taken, 0);
            n++;
            tick();
        end
        b0.u_valid = 0; b0.p_en = 0;
        check("init_busy_cycles", n, 16);
        check("init_index_held", b0.p_index, 0);
        check("init_branches", b0.stat_branches, 0);
        check("init_hits", b0.stat_hits, 0);

        for (int i = 0; i < 16; i++) begin
            lookup0(32'(i * 4));
            check("sweep_index", b0.p_index, 32'(i));
            check("sweep_cnt", b0.p_cnt, 1);
            check("sweep_taken", b0.p_taken, 0);
        end

        lookup0(32'h14);
        check("sat_start", b0.p_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            upd0(4'd5, b0.p_cnt, 1'b1, b0.p_taken);
            lookup0(32'h14);
            check("sat_up_cnt", b0.p_cnt, 32'(sat_up[i]));
            check("sat_up_taken", b0.p_taken, 1);
        end
        for (int i = 0; i < 4; i++) begin
            upd0(4'd5, b0.p_cnt, 1'b0, b0.p_taken);
            lookup0(32'h14);
            check("sat_dn_cnt", b0.p_cnt, 32'(sat_dn[i]));
            check("sat_dn_taken", b0.p_taken, 32'(tk_dn[i]));
        end
        check("sat_branches", b0.stat_branches, 7);
        check("sat_hits", b0.stat_hits, 4);

        b0.p_pc = 32'h1C; b0.p_en = 1;
        b0.u_valid = 1; b0.u_index = 4'd7; b0.u_cnt = 2'd1; b0.u_taken = 1; b0.u_pred = 0;
        tick();
        b0.u_valid = 0; b0.p_en = 0;
        check("bypass_index", b0.p_index, 7);
        check("bypass_cnt", b0.p_cnt, 2);
        check("bypass_taken", b0.p_taken, 1);
        for (int i = 0; i < 3; i++) begin
            b0.p_pc = 32'(32'h40 + i * 8);
            tick();
            check("stall_index", b0.p_index, 7);
            check("stall_cnt", b0.p_cnt, 2);
        end
        check("bypass_branches", b0.stat_branches, 8);
        check("bypass_hits", b0.stat_hits, 4);

        for (int i = 0; i < 3; i++) begin
            upd1(4'd0, 2'd1, gs_tk[i], 1'b0);
        end
        // Fourth resolution alongside a lookup: hash uses ghr=0101, not 1011.
        b1.p_pc = 32'h08; b1.p_en = 1;
        b1.u_valid = 1; b1.u_index = 4'd0; b1.u_cnt = 2'd1; b1.u_taken = 1; b1.u_pred = 0;
        tick();
        b1.u_valid = 0; b1.p_en = 0;
        check("gs_preshift_index", b1.p_index, 7);
        check("gs_preshift_cnt", b1.p_cnt, 1);
        lookup1(32'h08);
        check("gs_index", b1.p_index, 9);
        check("gs_cnt", b1.p_cnt, 1);
        lookup1(32'h2C);
        check("gs_entry0_index", b1.p_index, 0);
        check("gs_entry0_cnt", b1.p_cnt, 2);
        check("gs_entry0_taken", b1.p_taken, 1);
        check("gs_branches", b1.stat_branches, 4);
        check("gs_hits", b1.stat_hits, 1);

        upd0(4'd3, 2'd1, 1'b1, 1'b1);
        upd0(4'd3, 2'd2, 1'b1, 1'b1);
        lookup0(32'h0C);
        check("train_cnt", b0.p_cnt, 3);
        resetn = 0;
        tick();
        check("rerst_busy0", busy0, 1);
        check("rerst_busy1", busy1, 1);
        check("rerst_index", b0.p_index, 0);
        check("rerst_cnt", b0.p_cnt, 1);
        check("rerst_taken", b0.p_taken, 0);
        check("rerst_branches", b0.stat_branches, 0);
        check("rerst_hits", b0.stat_hits, 0);
        check("rerst_gs_branches", b1.stat_branches, 0);
        resetn = 1;
        n = 0;
        while (busy0 && n < 100) begin
            n++;
            tick();
        end
        check("rerst_busy_cycles", n, 16);
        lookup0(32'h0C);
        check("rerst_entry3_index", b0.p_index, 3);
        check("rerst_entry3_cnt", b0.p_cnt, 1);
        lookup1(32'h08);
        check("rerst_ghr_index", b1.p_index, 2);

        for (int i = 0; i < 10; i++) begin
            upd0(4'd10, 2'd1, st_tk[i], st_pr[i]);
        end
        check("stat_branches", b0.stat_branches, 10);
        check("stat_hits", b0.stat_hits, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
